uart_tx_ctrl: RTL
=================

# uart_tx_ctrl

UART transmit sequencer that owns the baud counter. It accepts one byte per valid/ready handshake and latches the baud divisor for the frame. It enables the baud counter and advances one serial bit per counter tick, producing start, data (LSB first), optional parity and stop bits on `txd`. It sits between the byte source and the `baud_counter` instance, which it configures and gates exclusively.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5–8.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `cfg_baud`  in  20  requested divisor; sampled only at byte acceptance.
- `tx_valid`  in  1  byte offered.
- `tx_data`  in  8  byte; only bits [DATA_BITS-1:0] are sent.
- `tx_ready`  out  1  controller can accept a byte.
- `bc_en`  out  1  enable to the baud counter.
- `bc_baud`  out  20  divisor to the baud counter.
- `bc_tick`  in  1  baud counter pulse; high one cycle per bit period.
- `txd`  out  1  serial line, idle high.
- `busy`  out  1  frame in progress.

## Operation
- FSM states: IDLE, START, DATA, PAR, STOP.
- Reset values: state IDLE, `txd`=1, `bc_en`=0, `bc_baud`=0, `busy`=0, bit counter 0, shift register 0.
- `tx_ready` = (state==IDLE) && (`cfg_baud` != 0). It is combinational from registered state. A divisor of 0 blocks acceptance.
- IDLE: on `tx_valid`&&`tx_ready`:
  - latch `tx_data` into the shift register and `cfg_baud` into `bc_baud`;
  - compute parity over the DATA_BITS data bits;
  - go to START with `txd`<=0, `bc_en`<=1, `busy`<=1.
- START: on `bc_tick`, go to DATA; `txd`<=data bit 0.
- DATA: on each `bc_tick`, shift and output the next bit. After DATA_BITS ticks:
  - go to PAR if PARITY≠0, with `txd`<=parity bit (even: XOR of data; odd: inverted XOR);
  - otherwise go to STOP with `txd`<=1.
- PAR: on `bc_tick`, go to STOP with `txd`<=1.
- STOP: hold `txd`=1. After STOP_BITS ticks, go to IDLE with `bc_en`<=0 and `busy`<=0.
- Frame length in ticks: 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
- `bc_tick` is ignored in IDLE.
- Changes to `cfg_baud` mid-frame have no effect; `bc_baud` is stable from acceptance to frame end. `bc_baud` keeps its last value in IDLE.
- Reset asserted mid-frame: all registers return to reset values on that edge. `txd` goes high, `bc_en` goes low, and the frame is abandoned with no completion.

## Timing
- Acceptance at edge N: at N+1, `txd`=0, `bc_en`=1, `busy`=1, `tx_ready`=0.
- Each bit changes on the edge that samples `bc_tick` high. Bit period equals tick spacing; the controller adds no extra cycles.
- Final stop tick sampled at edge M: at M+1, state is IDLE, `bc_en`=0, `tx_ready`=1.
- Back-to-back: a byte accepted at M+1 gives `bc_en` low for exactly one cycle (M+1 to M+2). The baud counter therefore restarts from zero for every frame.
- All outputs except `tx_ready` are registered; no combinational path from `bc_tick` to `txd`.
- `tx_data` and `cfg_baud` need only be valid in the acceptance cycle.

## Test plan
- Defaults, `cfg_baud`=20, send 0xA5 → `bc_baud`=20. `txd` bits per tick are 0,1,0,1,0,0,1,0,1,1. `tx_ready` returns high the cycle after the 10th tick.
- PARITY=1, send 0x07 → parity bit 1; PARITY=2, same byte → parity bit 0. Frame is 11 ticks.
- Change `cfg_baud` 20→7 during DATA → `bc_baud` stays 20 until frame end. The next accepted byte gives `bc_baud`=7.
- Two bytes, `tx_valid` held high → second accepted the cycle after IDLE re-entry. `bc_en` is low for exactly one cycle between frames and `txd` shows no glitch.
- `rstn` low for one cycle during DATA bit 3 → next cycle `txd`=1, `bc_en`=0, `busy`=0, `tx_ready`=1. A new 0x3C frame then transmits correctly.
- `cfg_baud`=0 with `tx_valid`=1 → `tx_ready`=0, no frame starts, `txd` stays 1. Stray `bc_tick` pulses in IDLE change nothing.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl -- UART transmit sequencer that configures and gates a baud counter.
// Revision 1.0
`default_nettype none

module uart_tx_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [19:0] cfg_baud,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        bc_en,
  output logic [19:0] bc_baud,
  input  logic        bc_tick,
  output logic        txd,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  localparam logic [7:0] c_data_mask = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0] c_last_data = 3'(DATA_BITS - 1);
  localparam logic [2:0] c_last_stop = 3'(STOP_BITS - 1);
  localparam logic       c_has_par   = (PARITY != 0);
  localparam logic       c_odd_par   = (PARITY == 2);

  state_t      state_q;
  logic        txd_q;
  logic        bc_en_q;
  logic        busy_q;
  logic        par_q;
  logic [19:0] bc_baud_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        w_accept;

  // A zero divisor would stall the baud counter forever, so it blocks acceptance.
  assign tx_ready = (state_q == S_IDLE) && (cfg_baud != 20'd0);
  assign w_accept = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      txd_q     <= 1'b1;
      bc_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      par_q     <= 1'b0;
      bc_baud_q <= 20'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            shift_q   <= tx_data;
            bc_baud_q <= cfg_baud;
            par_q     <= (^(tx_data & c_data_mask)) ^ c_odd_par;
            bit_cnt_q <= 3'd0;
            txd_q     <= 1'b0;
            bc_en_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_START;
          end
        end
        S_START: begin
          if (bc_tick) begin
            txd_q     <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_cnt_q <= 3'd0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          // Bit 0 went out on the START tick, so the last DATA tick closes the final bit.
          if (bc_tick) begin
            if (bit_cnt_q == c_last_data) begin
              bit_cnt_q <= 3'd0;
              if (c_has_par) begin
                txd_q   <= par_q;
                state_q <= S_PAR;
              end else begin
                txd_q   <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              txd_q     <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        S_PAR: begin
          if (bc_tick) begin
            txd_q     <= 1'b1;
            bit_cnt_q <= 3'd0;
            state_q   <= S_STOP;
          end
        end
        S_STOP: begin
          if (bc_tick) begin
            if (bit_cnt_q == c_last_stop) begin
              bit_cnt_q <= 3'd0;
              bc_en_q   <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        default: begin
          txd_q   <= 1'b1;
          bc_en_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign txd     = txd_q;
  assign bc_en   = bc_en_q;
  assign busy    = busy_q;
  assign bc_baud = bc_baud_q;

endmodule

`default_nettype wire
